// File: rtl/bank_access_scheduler.sv
// Dual-port scheduler in front of a 4-bank synchronous memory.
// Bank is picked by the two address MSBs; different-bank requests issue together,
// same-bank requests are arbitrated round-robin per bank. Read latency is 3 cycles.
module bank_access_scheduler #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic                                   i_a_valid,
  output logic                                   o_a_ready,
  input  logic                                   i_a_wen,
  input  logic [ADDR_WIDTH-1:0]                  i_a_addr,
  input  logic [DATA_WIDTH-1:0]                  i_a_wdata,
  output logic                                   o_a_rvalid,
  output logic [DATA_WIDTH-1:0]                  o_a_rdata,
  input  logic                                   i_b_valid,
  output logic                                   o_b_ready,
  input  logic                                   i_b_wen,
  input  logic [ADDR_WIDTH-1:0]                  i_b_addr,
  input  logic [DATA_WIDTH-1:0]                  i_b_wdata,
  output logic                                   o_b_rvalid,
  output logic [DATA_WIDTH-1:0]                  o_b_rdata,
  output logic [3:0]                             o_bank_en,
  output logic [3:0]                             o_bank_wen,
  output logic [4*(ADDR_WIDTH-2)-1:0]            o_bank_addr,
  output logic [4*DATA_WIDTH-1:0]                o_bank_wdata,
  input  logic [4*DATA_WIDTH-1:0]                i_bank_rdata,
  output logic [CNT_WIDTH-1:0]                   o_conflict_cnt
);

  localparam int unsigned NUM_BANKS   = 4;
  localparam int unsigned LOCAL_WIDTH = ADDR_WIDTH - 2;

  typedef struct packed {
    logic       rd;
    logic [1:0] bank;
  } rd_tag_t;

  logic [1:0]           sel_a;
  logic [1:0]           sel_b;
  logic                 conflict;
  logic                 grant_a;
  logic                 grant_b;
  logic [NUM_BANKS-1:0] prio;
  rd_tag_t              a_p0, a_p1, b_p0, b_p1;
  logic [DATA_WIDTH-1:0] bank_rd [NUM_BANKS];

  // Arbitration: prio[bank]=0 favours A, 1 favours B; nothing granted during reset
  always_comb begin
    sel_a    = i_a_addr[ADDR_WIDTH-1 -: 2];
    sel_b    = i_b_addr[ADDR_WIDTH-1 -: 2];
    conflict = i_a_valid & i_b_valid & (sel_a == sel_b);
    grant_a  = ~i_rst & i_a_valid & (~conflict | ~prio[sel_a]);
    grant_b  = ~i_rst & i_b_valid & (~conflict |  prio[sel_a]);
  end

  assign o_a_ready = grant_a;
  assign o_b_ready = grant_b;

  // Split the packed read-data bus into per-bank lanes
  always_comb begin
    for (int k = 0; k < NUM_BANKS; k++) begin
      bank_rd[k] = i_bank_rdata[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Per-bank round-robin priority and saturating conflict counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prio           <= '0;
      o_conflict_cnt <= '0;
    end else if (conflict) begin
      prio[sel_a] <= ~prio[sel_a];
      if (o_conflict_cnt != {CNT_WIDTH{1'b1}}) begin
        o_conflict_cnt <= o_conflict_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Bank lanes: strobes pulse for one cycle, addr/wdata hold when idle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_bank_en    <= '0;
      o_bank_wen   <= '0;
      o_bank_addr  <= '0;
      o_bank_wdata <= '0;
    end else begin
      for (int k = 0; k < NUM_BANKS; k++) begin
        o_bank_en[k]  <= 1'b0;
        o_bank_wen[k] <= 1'b0;
        if (grant_a && (sel_a == 2'(k))) begin
          o_bank_en[k]                                  <= 1'b1;
          o_bank_wen[k]                                 <= i_a_wen;
          o_bank_addr[k*LOCAL_WIDTH +: LOCAL_WIDTH]     <= i_a_addr[LOCAL_WIDTH-1:0];
          o_bank_wdata[k*DATA_WIDTH +: DATA_WIDTH]      <= i_a_wdata;
        end else if (grant_b && (sel_b == 2'(k))) begin
          o_bank_en[k]                                  <= 1'b1;
          o_bank_wen[k]                                 <= i_b_wen;
          o_bank_addr[k*LOCAL_WIDTH +: LOCAL_WIDTH]     <= i_b_addr[LOCAL_WIDTH-1:0];
          o_bank_wdata[k*DATA_WIDTH +: DATA_WIDTH]      <= i_b_wdata;
        end
      end
    end
  end

  // Read-return pipeline: tag at strobe, tag at bank data, then registered return
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_p0       <= '0;
      a_p1       <= '0;
      b_p0       <= '0;
      b_p1       <= '0;
      o_a_rvalid <= 1'b0;
      o_b_rvalid <= 1'b0;
      o_a_rdata  <= '0;
      o_b_rdata  <= '0;
    end else begin
      a_p0.rd    <= grant_a & ~i_a_wen;
      a_p0.bank  <= sel_a;
      b_p0.rd    <= grant_b & ~i_b_wen;
      b_p0.bank  <= sel_b;
      a_p1       <= a_p0;
      b_p1       <= b_p0;
      o_a_rvalid <= a_p1.rd;
      o_b_rvalid <= b_p1.rd;
      if (a_p1.rd) begin
        o_a_rdata <= bank_rd[a_p1.bank];
      end
      if (b_p1.rd) begin
        o_b_rdata <= bank_rd[b_p1.bank];
      end
    end
  end

endmodule
